// File: rtl/frac_pkg.sv
// rtl/frac_pkg.sv - shared constants, frame types and FSM states for the fractional frame transmitter
package frac_pkg;

    localparam int          CTR_NUM    = 8;
    localparam int          FIFO_DEPTH = 2;
    localparam logic [7:0]  FRAME_HDR  = 8'hA5;

    typedef logic [6:0] frac_code_t;

    typedef struct packed {
        logic [7:0]                seq;
        frac_code_t [CTR_NUM-1:0]  code;
    } frame_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_SEQ,
        S_DATA,
        S_CSUM
    } tx_state_t;

    // A 7-bit code travels as a byte with the top bit cleared.
    function automatic logic [7:0] code_byte(input frac_code_t c);
        return {1'b0, c};
    endfunction

endpackage

// File: rtl/frac_frame_tx_if.sv
// rtl/frac_frame_tx_if.sv - frame input strobe and byte output handshake bundle
interface frac_frame_tx_if
    import frac_pkg::*;
#(
    parameter int CTR_NUM = frac_pkg::CTR_NUM
);

    frac_code_t  in_data [CTR_NUM-1:0];
    logic        in_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output in_data,
        output in_valid,
        output tx_ready,
        input  tx_data,
        input  tx_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  tx_ready,
        output tx_data,
        output tx_valid
    );

endinterface

// File: rtl/frac_frame_fifo.sv
// rtl/frac_frame_fifo.sv - single-clock FIFO holding whole frames, head exposed combinationally
module frac_frame_fifo
    import frac_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = frame_t
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output entry_t                 head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    entry_t      mem_q [DEPTH];
    entry_t      mem_d [DEPTH];

    // Status flags: pointers carry one extra wrap bit so full and empty differ.
    always_comb begin
        count = wr_ptr_q - rd_ptr_q;
        full  = (count == (AW+1)'(DEPTH));
        empty = (wr_ptr_q == rd_ptr_q);
        head  = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Next storage and pointers; the caller only pushes when there is room.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Storage and pointer registers, emptied on reset.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/frac_frame_tx.sv
// rtl/frac_frame_tx.sv - buffers fractional-code frames and streams them out as checksummed bytes
module frac_frame_tx
    import frac_pkg::*;
#(
    parameter int         CTR_NUM    = frac_pkg::CTR_NUM,
    parameter int         FIFO_DEPTH = frac_pkg::FIFO_DEPTH,
    parameter logic [7:0] FRAME_HDR  = frac_pkg::FRAME_HDR
) (
    input  logic              clock,
    input  logic              rst,
    frac_frame_tx_if.slave    bus,
    output logic [15:0]       drop_cnt,
    output logic              busy
);

    localparam int IW = (CTR_NUM > 1) ? $clog2(CTR_NUM) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [7:0]                seq;
        frac_code_t [CTR_NUM-1:0]  code;
    } entry_t;

    tx_state_t   state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  seq_q, seq_d;
    logic [15:0] drop_q, drop_d;

    entry_t      wr_entry;
    entry_t      head;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CW-1:0] fifo_count;
    logic        push;
    logic        pop;
    logic        xfer;
    logic [IW-1:0] idx_next;

    frac_frame_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clock     (clock),
        .rst       (rst),
        .push      (push),
        .push_data (wr_entry),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (head)
    );

    assign xfer         = tx_valid_q && bus.tx_ready;
    assign idx_next     = idx_q + 1'b1;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign drop_cnt     = drop_q;
    assign busy         = !fifo_empty || (state_q != S_IDLE);

    // Incoming frame is tagged with the sequence number it arrived under.
    always_comb begin
        wr_entry.seq = seq_q;
        for (int i = 0; i < CTR_NUM; i++) begin
            wr_entry.code[i] = bus.in_data[i];
        end
    end

    // Transmit FSM: byte selection, running checksum and head pop.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    tx_data_d  = FRAME_HDR;
                    tx_valid_d = 1'b1;
                    csum_d     = '0;
                    state_d    = S_HDR;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    csum_d    = csum_q ^ tx_data_q;
                    tx_data_d = head.seq;
                    state_d   = S_SEQ;
                end
            end
            S_SEQ: begin
                if (xfer) begin
                    csum_d    = csum_q ^ tx_data_q;
                    tx_data_d = code_byte(head.code[0]);
                    idx_d     = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    csum_d = csum_q ^ tx_data_q;
                    if (idx_q == IW'(CTR_NUM - 1)) begin
                        tx_data_d = csum_q ^ tx_data_q;
                        state_d   = S_CSUM;
                    end else begin
                        idx_d     = idx_next;
                        tx_data_d = code_byte(head.code[idx_next]);
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    pop = 1'b1;
                    // A frame arriving on this edge always fits, since the pop frees a slot.
                    if ((fifo_count != CW'(1)) || bus.in_valid) begin
                        tx_data_d = FRAME_HDR;
                        csum_d    = '0;
                        state_d   = S_HDR;
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    // Sequence numbering counts every strobe; lost frames bump the saturating drop counter.
    always_comb begin
        seq_d  = seq_q;
        drop_d = drop_q;
        push   = bus.in_valid && (!fifo_full || pop);
        if (bus.in_valid) begin
            seq_d = seq_q + 8'd1;
            if (!push && (drop_q != 16'hFFFF)) begin
                drop_d = drop_q + 16'd1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            idx_q      <= '0;
            csum_q     <= '0;
            seq_q      <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            seq_q      <= seq_d;
            drop_q     <= drop_d;
        end
    end

endmodule

// File: tb/tb_frac_frame_tx.sv
// tb/tb_frac_frame_tx.sv - self-checking bench for frac_frame_tx against a frame-queue model
module tb_frac_frame_tx;

    localparam int N     = 8;
    localparam int DEPTH = 2;
    localparam int FLEN  = N + 3;

    logic        clock = 1'b0;
    logic        rst   = 1'b0;
    logic [15:0] drop_cnt;
    logic        busy;

    frac_frame_tx_if #(.CTR_NUM(N)) bus();

    frac_frame_tx #(
        .CTR_NUM    (N),
        .FIFO_DEPTH (DEPTH),
        .FRAME_HDR  (8'hA5)
    ) dut (
        .clock    (clock),
        .rst      (rst),
        .bus      (bus),
        .drop_cnt (drop_cnt),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: queue of accepted frames, head byte position, sequence and drop counters.
    typedef struct {
        logic [7:0] seq;
        logic [6:0] c [N];
    } mframe_t;

    mframe_t    mq [$];
    mframe_t    m_new;
    int         m_pos;
    logic       m_valid;
    logic [7:0] m_seq;
    int         m_drop;
    bit         m_had;
    bit         m_pop;

    function automatic logic [7:0] frame_byte(input mframe_t f, input int p);
        logic [7:0] x;
        if (p == 0) return 8'hA5;
        if (p == 1) return f.seq;
        if (p <= N + 1) return {1'b0, f.c[p-2]};
        x = 8'hA5 ^ f.seq;
        for (int i = 0; i < N; i++) x = x ^ {1'b0, f.c[i]};
        return x;
    endfunction

    always @(posedge clock or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_pos   = 0;
            m_valid = 1'b0;
            m_seq   = 8'd0;
            m_drop  = 0;
        end else begin
            m_had = (mq.size() != 0);
            m_pop = 1'b0;
            if (m_valid && bus.tx_ready) begin
                if (m_pos == FLEN - 1) begin
                    m_pop = 1'b1;
                    m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
            if (bus.in_valid) begin
                if (mq.size() < DEPTH || m_pop) begin
                    m_new.seq = m_seq;
                    for (int i = 0; i < N; i++) m_new.c[i] = bus.in_data[i];
                    if (m_pop) void'(mq.pop_front());
                    mq.push_back(m_new);
                    m_pop = 1'b0;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
                m_seq = m_seq + 8'd1;
            end
            if (m_pop) void'(mq.pop_front());
            m_valid = m_had && (mq.size() != 0);
        end
    end

    logic [7:0] rx [$];

    // Compare against the model and record accepted bytes, away from the active edge.
    always @(negedge clock) begin
        if (rst) begin
            check("tx_valid", {31'd0, bus.tx_valid}, {31'd0, m_valid});
            check("busy", {31'd0, busy}, {31'd0, mq.size() != 0});
            check("drop_cnt", {16'd0, drop_cnt}, m_drop);
            if (m_valid) check("tx_data", {24'd0, bus.tx_data}, {24'd0, frame_byte(mq[0], m_pos)});
            if (bus.tx_valid && bus.tx_ready) rx.push_back(bus.tx_data);
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic set_frame(input int base, input int step);
        for (int i = 0; i < N; i++) bus.in_data[i] = 7'((base + step * i) & 127);
    endtask

    task automatic strobe();
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((busy || bus.tx_valid) && k < budget) begin
            tick();
            k++;
        end
        check("idle_timeout", {31'd0, k < budget}, 32'd1);
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rx.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("rx_timeout", {31'd0, k < budget}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_drop", {16'd0, drop_cnt}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    logic [7:0] exp1 [FLEN] = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                                8'h05, 8'h06, 8'h07, 8'h08, 8'hAD};

    initial begin
        bus.in_valid = 1'b0;
        bus.tx_ready = 1'b0;
        set_frame(0, 0);
        #3;

        // Single frame, always ready, with latency checks.
        do_reset();
        rx.delete();
        bus.tx_ready = 1'b1;
        set_frame(1, 1);
        strobe();
        check("lat_before", {31'd0, bus.tx_valid}, 32'd0);
        tick();
        check("lat_after", {31'd0, bus.tx_valid}, 32'd1);
        wait_idle(40);
        check("t1_len", rx.size(), FLEN);
        for (int i = 0; i < FLEN && i < rx.size(); i++) check("t1_byte", {24'd0, rx[i]}, {24'd0, exp1[i]});
        check("t1_busy_end", {31'd0, busy}, 32'd0);

        // Same frame with tx_ready toggling every cycle.
        do_reset();
        rx.delete();
        bus.tx_ready = 1'b1;
        set_frame(1, 1);
        strobe();
        for (int k = 0; k < 80 && (busy || bus.tx_valid); k++) begin
            bus.tx_ready = ~bus.tx_ready;
            tick();
        end
        check("t2_len", rx.size(), FLEN);
        for (int i = 0; i < FLEN && i < rx.size(); i++) check("t2_byte", {24'd0, rx[i]}, {24'd0, exp1[i]});

        // Overflow: three strobes while stalled, third is dropped.
        do_reset();
        rx.delete();
        bus.tx_ready = 1'b0;
        set_frame(1, 1);
        strobe();
        set_frame(10, 2);
        strobe();
        set_frame(20, 3);
        strobe();
        tick();
        check("t3_drop", {16'd0, drop_cnt}, 32'd1);
        bus.tx_ready = 1'b1;
        wait_idle(60);
        check("t3_len", rx.size(), 2 * FLEN);
        if (rx.size() >= 2 * FLEN) begin
            check("t3_seq0", {24'd0, rx[1]}, 32'h00);
            check("t3_hdr1", {24'd0, rx[FLEN]}, 32'hA5);
            check("t3_seq1", {24'd0, rx[FLEN+1]}, 32'h01);
        end

        // Full FIFO with a new frame on the final checksum transfer.
        do_reset();
        rx.delete();
        bus.tx_ready = 1'b0;
        set_frame(1, 1);
        strobe();
        set_frame(10, 2);
        strobe();
        bus.tx_ready = 1'b1;
        wait_rx(FLEN - 1, 50);
        set_frame(30, 1);
        strobe();
        check("t4_drop", {16'd0, drop_cnt}, 32'd0);
        wait_idle(80);
        check("t4_len", rx.size(), 3 * FLEN);
        if (rx.size() >= 3 * FLEN) begin
            check("t4_hdr2", {24'd0, rx[2*FLEN]}, 32'hA5);
            check("t4_seq2", {24'd0, rx[2*FLEN+1]}, 32'h02);
        end

        // Reset in the middle of the data bytes.
        do_reset();
        rx.delete();
        bus.tx_ready = 1'b1;
        set_frame(1, 1);
        strobe();
        wait_rx(6, 40);
        rst = 1'b0;
        #1;
        check("t5_valid_now", {31'd0, bus.tx_valid}, 32'd0);
        check("t5_busy_now", {31'd0, busy}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("t5_no_tail", {31'd0, bus.tx_valid}, 32'd0);
        rx.delete();
        set_frame(5, 7);
        strobe();
        wait_idle(40);
        check("t5_len", rx.size(), FLEN);
        if (rx.size() >= 2) begin
            check("t5_hdr", {24'd0, rx[0]}, 32'hA5);
            check("t5_seq", {24'd0, rx[1]}, 32'h00);
        end
        check("t5_drop", {16'd0, drop_cnt}, 32'd0);

        // 257 frames: sequence wraps FF -> 00.
        do_reset();
        rx.delete();
        bus.tx_ready = 1'b1;
        for (int k = 0; k < 257; k++) begin
            set_frame(k * 3, 5);
            strobe();
            wait_idle(40);
        end
        check("t6_len", rx.size(), 257 * FLEN);
        if (rx.size() >= 257 * FLEN) begin
            check("t6_seq_ff", {24'd0, rx[255*FLEN+1]}, 32'hFF);
            check("t6_seq_wrap", {24'd0, rx[256*FLEN+1]}, 32'h00);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

endmodule
